ps2_scancode_rx: RTL and testbench



---
 rtl/ps2_scancode_rx_if.sv | 25 ++
 rtl/ps2_scancode_rx.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: key event handshake between the PS/2 receiver and its consumer.
// Signals: ev_valid/ev_ready handshake, ev_code, ev_extended, ev_released.
interface ps2_scancode_rx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_extended;
    logic       ev_released;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_extended,
        output ev_released,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_extended,
        input  ev_released,
        output ev_ready
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard deframer with E0/F0 prefix folding and an event FIFO.
// Ports: clk, reset (sync, active-high), ps2_clk/ps2_data (raw pins),
//   ev (master handshake: valid/ready, code, extended, released),
//   frame_err, parity_err, overflow (one-cycle pulses).
// Build option: define PS2_PARITY_EN to enable odd-parity checking.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 6000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_scancode_rx_if.master  ev,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [FW-1:0] F_ONE  = FW'(1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   P_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Input synchronisers, idle-high
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       ps2c_s;
    logic       ps2d_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign ps2c_s = clk_sync[1];
    assign ps2d_s = dat_sync[1];

    // Clock filter: output flips after FILTER_LEN samples that disagree
    // with it; any agreeing sample restarts the run.
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b1;
            fcnt <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (ps2c_s == filt) begin
                fcnt <= '0;
            end else if (fcnt == F_LAST) begin
                filt <= ps2c_s;
                fcnt <= '0;
                fall <= filt;
            end else begin
                fcnt <= fcnt + F_ONE;
            end
        end
    end

    // Deframer
    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          byte_done;
    logic [7:0]    byte_q;
`ifdef PS2_PARITY_EN
    logic          par_bit;
    logic          par_fail;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
            byte_done <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_EN
            par_bit   <= 1'b0;
            par_fail  <= 1'b0;
`endif
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_EN
            par_fail  <= 1'b0;
`endif
            if (fall) begin
                // a fall always beats a coincident timeout
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!ps2d_s) begin
                            state <= DATA;
                            bcnt  <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {ps2d_s, shreg[7:1]};
                        bcnt  <= bcnt + 3'd1;
                        if (bcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_EN
                        par_bit <= ps2d_s;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!ps2d_s)
                            frame_err <= 1'b1;
`ifdef PS2_PARITY_EN
                        else if (!(^{shreg, par_bit}))
                            par_fail <= 1'b1;
`endif
                        else begin
                            byte_done <= 1'b1;
                            byte_q    <= shreg;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tcnt == T_LAST) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    tcnt      <= '0;
                    shreg     <= '0;
                end else begin
                    tcnt <= tcnt + T_ONE;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

`ifdef PS2_PARITY_EN
    assign parity_err = par_fail;
`else
    assign parity_err = 1'b0;
`endif

    // Prefix folding and event FIFO
    logic          ext_pend;
    logic          brk_pend;
    logic          is_e0;
    logic          is_f0;
    logic          push;
    logic          pop;
    logic          do_wr;
    logic          empty;
    logic          full;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [9:0]    head;

    assign is_e0 = (byte_q == 8'hE0);
    assign is_f0 = (byte_q == 8'hF0);
    assign push  = byte_done && !is_e0 && !is_f0;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && ev.ev_ready;
    // a same-cycle pop frees the slot, so a full FIFO still accepts
    assign do_wr = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (byte_done) begin
                if (is_e0) begin
                    ext_pend <= 1'b1;
                end else if (is_f0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            if (do_wr)
                wr_ptr <= wr_ptr + P_ONE;
            if (pop)
                rd_ptr <= rd_ptr + P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= {ext_pend, brk_pend, byte_q};
    end

    assign head           = mem[rd_ptr[AW-1:0]];
    assign ev.ev_valid    = !empty;
    assign ev.ev_code     = empty ? 8'h00 : head[7:0];
    assign ev.ev_extended = empty ? 1'b0 : head[9];
    assign ev.ev_released = empty ? 1'b0 : head[8];
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed and random PS/2 frames against a queue-based event model.
// Ports of the DUT all connected; the bench drives the raw pins and the ready input.
module tb_ps2_scancode_rx;
    localparam int H = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic frame_err;
    logic parity_err;
    logic overflow;

    ps2_scancode_rx_if ev_if ();

    ps2_scancode_rx dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ev         (ev_if.master),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_pe = 0;
    int exp_ov = 0;
    bit m_ext = 0;
    bit m_brk = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        fe_cnt += int'(frame_err);
        pe_cnt += int'(parity_err);
        ov_cnt += int'(overflow);
        if (ev_if.ev_valid && ev_if.ev_ready)
            got_q.push_back({ev_if.ev_extended, ev_if.ev_released,
                             ev_if.ev_code});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Event model: prefixes set flags, other bytes become events
    // unless four are already waiting in the DUT.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (exp_q.size() - got_q.size() >= 4)
                exp_ov++;
            else
                exp_q.push_back({m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(40);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 0, 0, 11);
        model_byte(b);
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_fe"}, fe_cnt, exp_fe);
        chk({tag, "_pe"}, pe_cnt, exp_pe);
        chk({tag, "_ov"}, ov_cnt, exp_ov);
    endtask

    task automatic check_events(input string tag);
        int n;
        ev_if.ev_ready = 1'b1;
        wait_cyc(10);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_ev"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, {ev_if.ev_valid, ev_if.ev_code, ev_if.ev_extended,
                  ev_if.ev_released, frame_err, parity_err, overflow},
            32'h0);
    endtask

    initial begin
        logic [7:0] b;
        ev_if.ev_ready = 1'b0;
        wait_cyc(5);
        check_idle_outputs("reset_outputs");
        reset = 1'b0;
        wait_cyc(20);

        // single make code, held then popped
        send(8'h1C);
        chk("t1_valid", ev_if.ev_valid, 1);
        chk("t1_code", ev_if.ev_code, 8'h1C);
        chk("t1_ext", ev_if.ev_extended, 0);
        chk("t1_rel", ev_if.ev_released, 0);
        ev_if.ev_ready = 1'b1;
        wait_cyc(1);
        ev_if.ev_ready = 1'b0;
        chk("t1_popped", ev_if.ev_valid, 0);
        check_events("t1");

        // extended break folds into one event
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_events("t2a");
        send(8'h75);
        check_events("t2b");

        // overflow on fifth code
        ev_if.ev_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            send(8'(i));
        chk("t3_ov_pulse", ov_cnt, 1);
        check_pulses("t3");
        check_events("t3");

        // wrong parity bit
        send_frame(8'h1C, 1, 0, 11);
`ifdef PS2_PARITY_EN
        exp_pe++;
`else
        model_byte(8'h1C);
`endif
        check_pulses("t4");
        check_events("t4");

        // bad stop bit
        send_frame(8'h33, 0, 1, 11);
        exp_fe++;
        check_pulses("t5");
        check_events("t5");

        // mid-frame timeout, then a clean code
        send_frame(8'h5A, 0, 0, 5);
        wait_cyc(9000);
        exp_fe++;
        check_pulses("t6a");
        send(8'h29);
        check_events("t6a");

        // timeout keeps a pending E0
        send(8'hE0);
        send_frame(8'hA5, 0, 0, 7);
        wait_cyc(9000);
        exp_fe++;
        check_pulses("t6b");
        send(8'h6C);
        check_events("t6b");

        // short glitch on the clock pin
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check_pulses("t6c");
        check_events("t6c");

        // reset mid-frame after E0
        send(8'hE0);
        send_frame(8'h55, 0, 0, 4);
        reset = 1'b1;
        wait_cyc(3);
        check_idle_outputs("t7_in_reset");
        reset = 1'b0;
        m_ext = 0;
        m_brk = 0;
        wait_cyc(20);
        send(8'h6B);
        check_events("t7");

        // random byte stream with random consumer stalls
        for (int i = 0; i < 24; i++) begin
            ev_if.ev_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            send(b);
        end
        check_pulses("t8");
        check_events("t8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
